// File: rtl/cpu_run_monitor_pkg.sv
// Shared encodings for the cpu run monitor: FSM state codes, LED colour
// indices and small state-class helpers.
package cpu_run_monitor_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_WAIT    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_PASS    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  localparam int LED_RED   = 0;
  localparam int LED_GREEN = 1;
  localparam int LED_BLUE  = 2;

  function automatic logic is_active(input state_t s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction

  function automatic logic is_terminal(input state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_monitor_led_blinker.sv
// Free-running 32-bit prescaler providing slow and fast blink taps for the
// status LED.
module led_blinker #(
  parameter int unsigned BLINK_LOG2 = 22
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_slow_blink,
  output logic o_fast_blink
);

  logic [31:0] presc_q, presc_d;
  logic        presc_unused;

  always_comb presc_d = presc_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  assign o_slow_blink = presc_q[BLINK_LOG2];
  assign o_fast_blink = presc_q[BLINK_LOG2-2];
  // Only two taps leave the block; fold the rest so nothing is dangling.
  assign presc_unused = ^presc_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Start-up sequencer and halt/watchdog monitor for the cpu core, reporting on
// the RGB LED. Define CPU_RUN_MONITOR_RESTART_EN to add the i_restart port.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES  = 3,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd1000000,
  parameter int unsigned BLINK_LOG2      = 22
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef CPU_RUN_MONITOR_RESTART_EN
  input  logic        i_restart,
`endif
  output logic        o_run,
  input  logic        i_running,
  input  logic        i_status,
  output logic        o_red,
  output logic        o_green,
  output logic        o_blue,
  output logic        o_done,
  output logic [31:0] o_cycles
);

  localparam logic [5:0]  STARTUP_INIT = 6'(STARTUP_CYCLES);
  localparam logic [31:0] WD_LAST      = WATCHDOG_CYCLES - 32'd1;

  state_t      state_q, state_d;
  logic [5:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] cycles_q, cycles_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic [2:0]  led_q, led_d;
  logic        slow_blink, fast_blink;
  logic        restart;
  logic        wd_expired;

`ifdef CPU_RUN_MONITOR_RESTART_EN
  assign restart = i_restart;
`else
  assign restart = 1'b0;
`endif

  led_blinker #(.BLINK_LOG2(BLINK_LOG2)) u_blinker (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_slow_blink (slow_blink),
    .o_fast_blink (fast_blink)
  );

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wd_d       = wd_q;
    cycles_d   = cycles_q;
    case (state_q)
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 6'd1;
        if (wait_cnt_q == 6'd1) begin
          state_d = ST_START;
          wd_d    = '0;
        end
      end
      // Expiry beats i_running here so the watchdog can never overrun.
      ST_START: begin
        wd_d = wd_q + 32'd1;
        if (wd_expired)     state_d = ST_TIMEOUT;
        else if (i_running) state_d = ST_RUN;
      end
      // A halt on the expiry cycle still reports PASS/FAIL.
      ST_RUN: begin
        wd_d = wd_q + 32'd1;
        if (!i_running)      state_d = i_status ? ST_PASS : ST_FAIL;
        else if (wd_expired) state_d = ST_TIMEOUT;
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (restart) begin
          state_d    = ST_WAIT;
          wait_cnt_d = STARTUP_INIT;
          cycles_d   = '0;
        end
      end
      default: begin
        state_d    = ST_WAIT;
        wait_cnt_d = STARTUP_INIT;
      end
    endcase
    if (is_active(state_d) && (cycles_q != 32'hFFFF_FFFF))
      cycles_d = cycles_q + 32'd1;
  end

  always_comb begin
    run_d  = is_active(state_d);
    done_d = is_terminal(state_d);
    led_d  = '0;
    case (state_d)
      ST_START, ST_RUN: led_d[LED_BLUE]  = slow_blink;
      ST_PASS:          led_d[LED_GREEN] = 1'b1;
      ST_FAIL:          led_d[LED_RED]   = slow_blink;
      ST_TIMEOUT:       led_d[LED_RED]   = fast_blink;
      default:          led_d            = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_WAIT;
      wait_cnt_q <= STARTUP_INIT;
      wd_q       <= '0;
      cycles_q   <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wd_q       <= wd_d;
      cycles_q   <= cycles_d;
      run_q      <= run_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign o_run    = run_q;
  assign o_done   = done_q;
  assign o_cycles = cycles_q;
  assign o_red    = led_q[LED_RED];
  assign o_green  = led_q[LED_GREEN];
  assign o_blue   = led_q[LED_BLUE];

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed test-plan scenarios plus random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_cpu_run_monitor;

  localparam int STARTUP = 3;
  localparam int WD      = 20;
  localparam int BL      = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        running = 1'b0;
  logic        status = 1'b0;
  logic        restart = 1'b0;
  logic        o_run, o_red, o_green, o_blue, o_done;
  logic [31:0] o_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .STARTUP_CYCLES  (STARTUP),
    .WATCHDOG_CYCLES (32'(WD)),
    .BLINK_LOG2      (BL)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef CPU_RUN_MONITOR_RESTART_EN
    .i_restart (restart),
`endif
    .o_run     (o_run),
    .i_running (running),
    .i_status  (status),
    .o_red     (o_red),
    .o_green   (o_green),
    .o_blue    (o_blue),
    .o_done    (o_done),
    .o_cycles  (o_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase of the run, how long we have waited, how many
  // cycles the core has been enabled, and cycles elapsed since reset.
  typedef enum int {M_WAITING, M_ARMED, M_RUNNING, M_DONE} mphase_e;
  typedef enum int {R_PASS, R_FAIL, R_TIMEOUT} mres_e;
  mphase_e     m_phase = M_WAITING;
  mres_e       m_res = R_PASS;
  int          m_waited = 0;
  int          m_active = 0;
  int unsigned m_presc = 0;
  logic        e_run = 0, e_done = 0, e_red = 0, e_green = 0, e_blue = 0;

  task automatic model_step();
    logic rs;
    rs = 1'b0;
`ifdef CPU_RUN_MONITOR_RESTART_EN
    rs = restart;
`endif
    if (!rst_n) begin
      m_phase = M_WAITING; m_waited = 0; m_active = 0; m_presc = 0;
      {e_run, e_done, e_red, e_green, e_blue} = '0;
      return;
    end
    case (m_phase)
      M_WAITING: begin
        m_waited++;
        if (m_waited == STARTUP) begin m_phase = M_ARMED; m_active = 1; end
      end
      M_ARMED: begin
        if (m_active == WD) begin m_phase = M_DONE; m_res = R_TIMEOUT; end
        else begin
          if (running) m_phase = M_RUNNING;
          m_active++;
        end
      end
      M_RUNNING: begin
        if (!running) begin m_phase = M_DONE; m_res = status ? R_PASS : R_FAIL; end
        else if (m_active == WD) begin m_phase = M_DONE; m_res = R_TIMEOUT; end
        else m_active++;
      end
      M_DONE: begin
        if (rs) begin m_phase = M_WAITING; m_waited = 0; m_active = 0; end
      end
      default: ;
    endcase
    e_run   = (m_phase == M_ARMED) || (m_phase == M_RUNNING);
    e_done  = (m_phase == M_DONE);
    e_blue  = e_run && ((m_presc >> BL) & 1) != 0;
    e_green = e_done && (m_res == R_PASS);
    e_red   = e_done && ((m_res == R_FAIL    && ((m_presc >> BL) & 1) != 0) ||
                         (m_res == R_TIMEOUT && ((m_presc >> (BL - 2)) & 1) != 0));
    m_presc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("run",    32'(o_run),   32'(e_run));
    chk("done",   32'(o_done),  32'(e_done));
    chk("red",    32'(o_red),   32'(e_red));
    chk("green",  32'(o_green), 32'(e_green));
    chk("blue",   32'(o_blue),  32'(e_blue));
    chk("cycles", o_cycles,     32'(m_active));
    chk("led_excl", 32'(int'(o_red) + int'(o_green) + int'(o_blue) > 1), 32'd0);
  endtask

  // Reset, release, and wait for o_run; leaves the bench just after o_run rose.
  task automatic start_fresh();
    int n;
    rst_n = 1'b0; running = 1'b0; status = 1'b0; restart = 1'b0;
    tick();
    chk("rst_cycles", o_cycles, 32'd0);
    chk("rst_run", 32'(o_run), 32'd0);
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!o_run && n < 10);
    chk("startup_edges", 32'(n), 32'(STARTUP));
  endtask

  task automatic halt_scenario(input logic st);
    start_fresh();
    tick();
    running = 1'b1;
    repeat (5) tick();
    running = 1'b0; status = st;
    tick();
    chk("halt_done",   32'(o_done),  32'd1);
    chk("halt_run",    32'(o_run),   32'd0);
    chk("halt_green",  32'(o_green), 32'(st));
    chk("halt_cycles", o_cycles,     32'd7);
  endtask

  task automatic count_red_toggles(input int span, output int tr);
    logic prev;
    tr = 0;
    prev = o_red;
    for (int i = 0; i < span; i++) begin
      tick();
      if (o_red != prev) tr++;
      prev = o_red;
    end
  endtask

  initial begin
    int n, tr;

    // Pass
    halt_scenario(1'b1);
    repeat (4) tick();
    chk("pass_sticky", 32'(o_green), 32'd1);

    // Fail, with slow blink on red
    halt_scenario(1'b0);
    count_red_toggles(16, tr);
    chk("fail_toggles", 32'(tr), 32'd2);

`ifdef CPU_RUN_MONITOR_RESTART_EN
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst_en_done",   32'(o_done), 32'd0);
    chk("rst_en_cycles", o_cycles,    32'd0);
    n = 0;
    do begin tick(); n++; end while (!o_run && n < 10);
    chk("rst_en_startup", 32'(n), 32'(STARTUP));
    running = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst_en_in_run", 32'(o_run), 32'd1);
`endif

    // Timeout with fast blink on red
    start_fresh();
    running = 1'b1;
    n = 0;
    while (!o_done && n < 40) begin tick(); n++; end
    chk("timeout_edges",  32'(n), 32'(WD));
    chk("timeout_cycles", o_cycles, 32'(WD));
    chk("timeout_green",  32'(o_green), 32'd0);
    count_red_toggles(8, tr);
    chk("timeout_toggles", 32'(tr), 32'd4);

    // Halt on the expiry cycle wins, then a one-cycle reset clears everything
    start_fresh();
    running = 1'b1;
    repeat (WD - 1) tick();
    running = 1'b0; status = 1'b1;
    tick();
    chk("tie_green",  32'(o_green), 32'd1);
    chk("tie_red",    32'(o_red),   32'd0);
    chk("tie_cycles", o_cycles,     32'(WD));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("tie_rst_all", {o_cycles[28:0], o_run, o_done, o_red | o_green | o_blue}, 32'd0);

    // Random stimulus, including glitches in WAIT/terminal and mid-run resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 5) == 0) running = ~running;
      status  = 1'($urandom_range(0, 1));
      restart = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout bench did not finish");
    $fatal(1);
  end

endmodule
